// File: rtl/display_source_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and default constants for the display source scheduler.
//   disp_state_t            : scheduler state (IDLE, SHOW, HOLD)
//   DEFAULT_NUM_SRC         : default number of requesters
//   DEFAULT_DWELL_CYCLES    : default cycles each source is shown in auto mode
//   DEFAULT_DEBOUNCE_CYCLES : default cycles the button must be stable
//   SRC_W                   : select width for the default source count
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        HOLD
    } disp_state_t;

    localparam int DEFAULT_NUM_SRC         = 4;
    localparam int DEFAULT_DWELL_CYCLES    = 100_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int SRC_W                   = $clog2(DEFAULT_NUM_SRC);

endpackage

// File: rtl/display_source_scheduler_if.sv
// ---------------------------------------------------------------------------
// display_source_scheduler_if
// Bundles the requester-side bus of the scheduler.
//   src_data : source i value on bits [32*i +: 32]
//   src_req  : level request per source
//   number   : value shown on the display
//   sel      : index of the selected source
//   src_ack  : one-hot single-cycle pulse when a source becomes selected
//   active   : high while a source is being shown
// master = requester/datapath side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface display_source_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic [32*NUM_SRC-1:0]       src_data;
    logic [NUM_SRC-1:0]          src_req;
    logic [31:0]                 number;
    logic [$clog2(NUM_SRC)-1:0]  sel;
    logic [NUM_SRC-1:0]          src_ack;
    logic                        active;

    modport master (
        output src_data,
        output src_req,
        input  number,
        input  sel,
        input  src_ack,
        input  active
    );

    modport slave (
        input  src_data,
        input  src_req,
        output number,
        output sel,
        output src_ack,
        output active
    );
endinterface

// File: rtl/display_source_scheduler_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Turns a raw asynchronous push-button into a single-cycle pulse.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   btn_raw   : raw button input
//   btn_pulse : one-cycle pulse on each accepted press (rising edge)
// Two-flop synchronizer, then a stability counter that restarts on any
// change, then a rising-edge detect on the accepted level.
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          btn_last;
    logic          btn_db;
    logic [CW-1:0] cnt;

    // btn_last tracks the synchronized level; once it has been unchanged for
    // DEBOUNCE_CYCLES it becomes the accepted level btn_db, and only a 0->1
    // change of the accepted level produces a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            btn_last  <= 1'b0;
            btn_db    <= 1'b0;
            cnt       <= '0;
            btn_pulse <= 1'b0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            btn_pulse <= 1'b0;
            if (sync2 != btn_last) begin
                btn_last <= sync2;
                cnt      <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else if (btn_db != btn_last) begin
                btn_db    <= btn_last;
                btn_pulse <= btn_last;
            end
        end
    end

endmodule

// File: rtl/display_source_scheduler.sv
// ---------------------------------------------------------------------------
// display_source_scheduler
// Time-shares the seven-segment display between NUM_SRC 32-bit requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_next   : raw push-button, advances the selection in manual mode
//   mode_auto  : 1 = round-robin auto rotate with dwell timer, 0 = manual
//   hold       : 1 = freeze display and selection
//   bus        : slave side of display_source_scheduler_if
//                (src_data, src_req in; number, sel, src_ack, active out)
// ---------------------------------------------------------------------------
module display_source_scheduler
    import display_pkg::*;
#(
    parameter int NUM_SRC         = DEFAULT_NUM_SRC,
    parameter int DWELL_CYCLES    = DEFAULT_DWELL_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_next,
    input  logic mode_auto,
    input  logic hold,
    display_source_scheduler_if.slave bus
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [SW-1:0]      LAST_SRC   = SW'(NUM_SRC - 1);
    localparam logic [DW-1:0]      DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [NUM_SRC-1:0] ACK_ONE    = NUM_SRC'(1);

    disp_state_t         state;
    logic [SW-1:0]       sel_q;
    logic [31:0]         number_q;
    logic [NUM_SRC-1:0]  ack_q;
    logic                active_q;
    logic [DW-1:0]       dwell;
    logic                mode_q;
    logic                btn_pulse;

    logic [SW-1:0]       rr_idx;
    logic                rr_found;
    logic [SW-1:0]       cand;
    logic [SW-1:0]       sel_inc;
    logic [31:0]         data_sel;
    logic [31:0]         data_inc;
    logic [31:0]         data_rr;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_next),
        .btn_pulse(btn_pulse)
    );

    // Round-robin search sel+1 .. sel+NUM_SRC; the last candidate is sel
    // itself, so a lone requester that is already shown is found again.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = sel_q;
        cand     = sel_q;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = SW'((int'(sel_q) + i) % NUM_SRC);
            if (!rr_found && bus.src_req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
        sel_inc  = (sel_q == LAST_SRC) ? '0 : sel_q + 1'b1;
        data_sel = bus.src_data[32*int'(sel_q)   +: 32];
        data_inc = bus.src_data[32*int'(sel_inc) +: 32];
        data_rr  = bus.src_data[32*int'(rr_idx)  +: 32];
    end

    // Main FSM. hold has priority in SHOW; in auto mode a mode toggle clears
    // the dwell before anything else, and a button press is treated like an
    // early expiry so both together still advance by a single requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            number_q <= '0;
            ack_q    <= '0;
            active_q <= 1'b0;
            dwell    <= '0;
            mode_q   <= 1'b0;
        end else begin
            ack_q  <= '0;
            mode_q <= mode_auto;
            unique case (state)
                IDLE: begin
                    dwell <= '0;
                    if (mode_auto) begin
                        if (rr_found) begin
                            state    <= SHOW;
                            active_q <= 1'b1;
                            sel_q    <= rr_idx;
                            number_q <= data_rr;
                            ack_q    <= ACK_ONE << rr_idx;
                        end
                    end else begin
                        state    <= SHOW;
                        active_q <= 1'b1;
                        number_q <= data_sel;
                        ack_q    <= ACK_ONE << sel_q;
                    end
                end
                SHOW: begin
                    if (hold) begin
                        state <= HOLD;
                    end else if (!mode_auto) begin
                        dwell <= '0;
                        if (btn_pulse) begin
                            sel_q    <= sel_inc;
                            number_q <= data_inc;
                            ack_q    <= ACK_ONE << sel_inc;
                        end else begin
                            number_q <= data_sel;
                        end
                    end else if (!mode_q) begin
                        dwell    <= '0;
                        number_q <= data_sel;
                    end else if (btn_pulse || dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (!rr_found) begin
                            state    <= IDLE;
                            active_q <= 1'b0;
                        end else begin
                            sel_q    <= rr_idx;
                            number_q <= data_rr;
                            if (rr_idx != sel_q) begin
                                ack_q <= ACK_ONE << rr_idx;
                            end
                        end
                    end else begin
                        dwell    <= dwell + 1'b1;
                        number_q <= data_sel;
                    end
                end
                HOLD: begin
                    if (mode_auto != mode_q) begin
                        dwell <= '0;
                    end
                    if (!hold) begin
                        state <= SHOW;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.number  = number_q;
    assign bus.sel     = sel_q;
    assign bus.src_ack = ack_q;
    assign bus.active  = active_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// ---------------------------------------------------------------------------
// tb_display_source_scheduler
// Self-checking bench for display_source_scheduler with NUM_SRC=4,
// DWELL_CYCLES=8, DEBOUNCE_CYCLES=4. Expected selections come from a
// round-robin reference function applied every dwell period.
// ---------------------------------------------------------------------------
module tb_display_source_scheduler;

    localparam int DWELL = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_next;
    logic mode_auto;
    logic hold;

    int checks = 0;
    int errors = 0;
    logic [31:0] data_arr [4];

    always #5 clk = ~clk;

    display_source_scheduler_if #(.NUM_SRC(4)) bus ();

    display_source_scheduler #(
        .NUM_SRC        (4),
        .DWELL_CYCLES   (DWELL),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .mode_auto(mode_auto),
        .hold     (hold),
        .bus      (bus)
    );

    // Next requester after cur in round-robin order, cur itself last; -1 if none.
    function automatic int next_req(int cur, logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (req[(cur + k) % 4]) return (cur + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_data();
        bus.src_data = {data_arr[3], data_arr[2], data_arr[1], data_arr[0]};
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        btn_next    = 1'b0;
        mode_auto   = 1'b0;
        hold        = 1'b0;
        bus.src_req = '0;
        for (int i = 0; i < 4; i++) data_arr[i] = 32'h1111_1111 * (i + 1);
        push_data();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.number !== 32'h0) begin errors++; $display("[TB] FAIL reset_number got %h exp 0", bus.number); end
        checks++;
        if (bus.sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel got %0d exp 0", bus.sel); end
        checks++;
        if (bus.src_ack !== 4'b0) begin errors++; $display("[TB] FAIL reset_ack got %b exp 0000", bus.src_ack); end
        checks++;
        if (bus.active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active got %b exp 0", bus.active); end
    endtask

    task automatic test_auto_rotate();
        int cur;
        int nxt;
        logic [3:0] req;
        logic [3:0] exp_ack;
        do_reset();
        req         = 4'b0101;
        bus.src_req = req;
        mode_auto   = 1'b1;
        tick();
        cur = next_req(0, req);
        checks++;
        if (bus.sel !== 2'(cur) || bus.number !== 32'h3333_3333 || bus.src_ack !== 4'b0100 || bus.active !== 1'b1)
            begin errors++; $display("[TB] FAIL auto_entry got sel=%0d num=%h ack=%b act=%b exp sel=2 num=33333333 ack=0100 act=1", bus.sel, bus.number, bus.src_ack, bus.active); end
        for (int c = 1; c <= 2 * DWELL; c++) begin
            tick();
            exp_ack = 4'b0;
            if (c % DWELL == 0) begin
                nxt = next_req(cur, req);
                if (nxt != cur) exp_ack = 4'b0001 << nxt;
                cur = nxt;
            end
            checks++;
            if (bus.sel !== 2'(cur) || bus.src_ack !== exp_ack || bus.number !== data_arr[cur])
                begin errors++; $display("[TB] FAIL auto_rotate c=%0d got sel=%0d ack=%b num=%h exp sel=%0d ack=%b num=%h", c, bus.sel, bus.src_ack, bus.number, cur, exp_ack, data_arr[cur]); end
        end
    endtask

    task automatic test_single_requester();
        int acks;
        do_reset();
        bus.src_req = 4'b0010;
        mode_auto   = 1'b1;
        tick();
        checks++;
        if (bus.sel !== 2'd1 || bus.src_ack !== 4'b0010)
            begin errors++; $display("[TB] FAIL single_entry got sel=%0d ack=%b exp sel=1 ack=0010", bus.sel, bus.src_ack); end
        acks = 0;
        for (int c = 0; c < 3 * DWELL; c++) begin
            tick();
            if (bus.src_ack !== 4'b0 || bus.sel !== 2'd1) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("[TB] FAIL single_persist got %0d extra acks/moves exp 0", acks); end
        bus.src_req = 4'b0;
        repeat (DWELL - 1) tick();
        checks++;
        if (bus.active !== 1'b1) begin errors++; $display("[TB] FAIL single_before_idle got active=%b exp 1", bus.active); end
        tick();
        checks++;
        if (bus.active !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got active=%b exp 0", bus.active); end
    endtask

    task automatic test_manual_debounce();
        int adv;
        int exp_sel;
        do_reset();
        tick();
        checks++;
        if (bus.sel !== 2'd0 || bus.src_ack !== 4'b0001 || bus.active !== 1'b1)
            begin errors++; $display("[TB] FAIL manual_entry got sel=%0d ack=%b act=%b exp sel=0 ack=0001 act=1", bus.sel, bus.src_ack, bus.active); end
        btn_next = 1'b1; tick();
        btn_next = 1'b0; tick();
        btn_next = 1'b1; tick();
        adv = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.src_ack !== 4'b0) adv++;
        end
        checks++;
        if (adv != 1 || bus.sel !== 2'd1)
            begin errors++; $display("[TB] FAIL bounce_advance got adv=%0d sel=%0d exp adv=1 sel=1", adv, bus.sel); end
        btn_next = 1'b0;
        repeat (12) tick();
        exp_sel = 1;
        for (int p = 0; p < 4; p++) begin
            adv = 0;
            btn_next = 1'b1;
            for (int c = 0; c < 15; c++) begin tick(); if (bus.src_ack !== 4'b0) adv++; end
            btn_next = 1'b0;
            for (int c = 0; c < 12; c++) begin tick(); if (bus.src_ack !== 4'b0) adv++; end
            exp_sel = (exp_sel + 1) % 4;
            checks++;
            if (adv != 1 || bus.sel !== 2'(exp_sel))
                begin errors++; $display("[TB] FAIL manual_press%0d got adv=%0d sel=%0d exp adv=1 sel=%0d", p, adv, bus.sel, exp_sel); end
        end
    endtask

    task automatic test_hold();
        int acks;
        do_reset();
        bus.src_req = 4'b1111;
        mode_auto   = 1'b1;
        tick();
        repeat (5) tick();
        hold = 1'b1;
        tick();
        checks++;
        if (bus.sel !== 2'd1 || bus.number !== 32'h2222_2222)
            begin errors++; $display("[TB] FAIL hold_enter got sel=%0d num=%h exp sel=1 num=22222222", bus.sel, bus.number); end
        for (int i = 0; i < 4; i++) data_arr[i] = $urandom;
        push_data();
        btn_next = 1'b1;
        acks = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) btn_next = 1'b0;
            tick();
            if (bus.src_ack !== 4'b0) acks++;
        end
        checks++;
        if (bus.sel !== 2'd1 || bus.number !== 32'h2222_2222 || acks != 0)
            begin errors++; $display("[TB] FAIL hold_frozen got sel=%0d num=%h acks=%0d exp sel=1 num=22222222 acks=0", bus.sel, bus.number, acks); end
        hold = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.sel !== 2'd1 || bus.number !== data_arr[1])
            begin errors++; $display("[TB] FAIL hold_resume got sel=%0d num=%h exp sel=1 num=%h", bus.sel, bus.number, data_arr[1]); end
        tick();
        checks++;
        if (bus.sel !== 2'd1) begin errors++; $display("[TB] FAIL hold_early_expiry got sel=%0d exp 1", bus.sel); end
        tick();
        checks++;
        if (bus.sel !== 2'd2 || bus.src_ack !== 4'b0100 || bus.number !== data_arr[2])
            begin errors++; $display("[TB] FAIL hold_expiry got sel=%0d ack=%b num=%h exp sel=2 ack=0100 num=%h", bus.sel, bus.src_ack, bus.number, data_arr[2]); end
    endtask

    task automatic test_button_on_expiry();
        int lat;
        int waited;
        // Measure button-to-advance latency in manual mode.
        do_reset();
        bus.src_req = 4'b1111;
        tick();
        btn_next = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (bus.sel === 2'd1) lat = k;
        end
        btn_next = 1'b0;
        checks++;
        if (lat < 1 || lat > DWELL) begin
            errors++;
            $display("[TB] FAIL btn_latency got %0d exp 1..%0d", lat, DWELL);
            return;
        end
        do_reset();
        bus.src_req = 4'b1111;
        mode_auto   = 1'b1;
        tick();
        waited = 0;
        while (bus.sel !== 2'd0 && waited < 40) begin tick(); waited++; end
        checks++;
        if (bus.sel !== 2'd0) begin errors++; $display("[TB] FAIL expiry_reach_sel0 got sel=%0d exp 0", bus.sel); return; end
        repeat (DWELL - lat) tick();
        btn_next = 1'b1;
        repeat (lat) tick();
        btn_next = 1'b0;
        checks++;
        if (bus.sel !== 2'd1 || bus.src_ack !== 4'b0010)
            begin errors++; $display("[TB] FAIL btn_expiry got sel=%0d ack=%b exp sel=1 ack=0010", bus.sel, bus.src_ack); end
        repeat (DWELL - 1) tick();
        checks++;
        if (bus.sel !== 2'd1) begin errors++; $display("[TB] FAIL btn_dwell_cleared got sel=%0d exp 1", bus.sel); end
        tick();
        checks++;
        if (bus.sel !== 2'd2) begin errors++; $display("[TB] FAIL btn_next_expiry got sel=%0d exp 2", bus.sel); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.src_req = 4'b1111;
        mode_auto   = 1'b1;
        tick();
        repeat (3) tick();
        checks++;
        if (bus.active !== 1'b1 || bus.sel !== 2'd1)
            begin errors++; $display("[TB] FAIL areset_pre got act=%b sel=%0d exp act=1 sel=1", bus.active, bus.sel); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.number !== 32'h0 || bus.sel !== 2'd0 || bus.src_ack !== 4'b0 || bus.active !== 1'b0)
            begin errors++; $display("[TB] FAIL areset got num=%h sel=%0d ack=%b act=%b exp all 0", bus.number, bus.sel, bus.src_ack, bus.active); end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.sel !== 2'd1 || bus.src_ack !== 4'b0010)
            begin errors++; $display("[TB] FAIL areset_restart got sel=%0d ack=%b exp sel=1 ack=0010", bus.sel, bus.src_ack); end
    endtask

    task automatic test_random_auto();
        int cur;
        int nxt;
        logic [3:0] req;
        logic [3:0] exp_ack;
        for (int iter = 0; iter < 6; iter++) begin
            do_reset();
            req = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) data_arr[i] = $urandom;
            push_data();
            bus.src_req = req;
            mode_auto   = 1'b1;
            tick();
            cur = next_req(0, req);
            checks++;
            if (bus.sel !== 2'(cur) || bus.src_ack !== (4'b0001 << cur) || bus.number !== data_arr[cur])
                begin errors++; $display("[TB] FAIL rand_entry req=%b got sel=%0d ack=%b exp sel=%0d", req, bus.sel, bus.src_ack, cur); end
            for (int c = 1; c <= 5 * DWELL; c++) begin
                for (int i = 0; i < 4; i++) data_arr[i] = $urandom;
                push_data();
                tick();
                exp_ack = 4'b0;
                if (c % DWELL == 0) begin
                    nxt = next_req(cur, req);
                    if (nxt != cur) exp_ack = 4'b0001 << nxt;
                    cur = nxt;
                end
                checks++;
                if (bus.sel !== 2'(cur) || bus.src_ack !== exp_ack || bus.number !== data_arr[cur])
                    begin errors++; $display("[TB] FAIL rand_rotate req=%b c=%0d got sel=%0d ack=%b num=%h exp sel=%0d ack=%b num=%h", req, c, bus.sel, bus.src_ack, bus.number, cur, exp_ack, data_arr[cur]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_rotate();
        test_single_requester();
        test_manual_debounce();
        test_hold();
        test_button_on_expiry();
        test_async_reset();
        test_random_auto();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

endmodule
